// File: rtl/npu_pkg.sv
// Shared definitions for the NPU activation MMIO slave: register map, modes, STATUS layout.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package npu_pkg;

    // Register offsets within the decoded low address window
    localparam int ADDR_CTRL   = 'h0;
    localparam int ADDR_INPUT  = 'h4;
    localparam int ADDR_OUTPUT = 'h8;
    localparam int ADDR_STATUS = 'hC;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_FLUSH  = 3;

    // STATUS bit positions
    localparam int STAT_IN_EMPTY  = 0;
    localparam int STAT_IN_FULL   = 1;
    localparam int STAT_OUT_EMPTY = 2;
    localparam int STAT_OUT_FULL  = 3;
    localparam int STAT_OVERFLOW  = 4;
    localparam int STAT_UNDERFLOW = 5;
    localparam int STAT_BUSY      = 6;
    localparam int STAT_CNT_LSB   = 8;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLAMP = 2'd3
    } act_mode_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous clear.
// Latency: a push is visible on rdata/empty the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; the caller gates both.
// Ports: clk/rst (sync, active-high), clear, push/wdata, pop/rdata, full, empty, count.
module sync_fifo #(
    parameter int DWidth = 32,
    parameter int Depth  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DWidth-1:0]        wdata,
    output logic [DWidth-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);

    logic [DWidth-1:0] mem [Depth];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;

    // The extra pointer MSB separates full from empty when the index bits match
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_act_mmio.sv
// Memory-mapped activation accelerator: INPUT FIFO -> 2-stage activation -> OUTPUT FIFO.
// Latency: INPUT write at edge t pops at t+1, stage 2 at t+2, output push at t+3; 1 elem/cycle.
// Backpressure: issue only while out_count + in-flight < FifoDepth; full INPUT drops + overflow.
// Ports: clk_i, rst_i (sync, active-high), cen_i/wen_i/addr_i/wdata_i bus, rdata_o (registered), irq_o.
module npu_act_mmio
    import npu_pkg::*;
#(
    parameter int DWidth     = 32,
    parameter int AddrWidth  = 8,
    parameter int FifoDepth  = 4,
    parameter int LeakyShift = 3,
    parameter int SatWidth   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cen_i,
    input  logic              wen_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    output logic [DWidth-1:0] rdata_o,
    output logic              irq_o
);

    localparam int CW = $clog2(FifoDepth) + 1;

    localparam logic signed [DWidth-1:0] SAT_MAX =
        {{(DWidth-SatWidth+1){1'b0}}, {(SatWidth-1){1'b1}}};
    localparam logic signed [DWidth-1:0] SAT_MIN =
        {{(DWidth-SatWidth+1){1'b1}}, {(SatWidth-1){1'b0}}};

    function automatic logic [DWidth-1:0] act_fn(input logic [DWidth-1:0] x,
                                                  input act_mode_e m);
        logic signed [DWidth-1:0] sx;
        sx     = $signed(x);
        act_fn = x;
        case (m)
            ACT_RELU:  if (sx < 0) act_fn = '0;
            ACT_LEAKY: if (sx < 0) act_fn = sx >>> LeakyShift;
            ACT_CLAMP: begin
                if (sx > SAT_MAX)      act_fn = SAT_MAX;
                else if (sx < SAT_MIN) act_fn = SAT_MIN;
            end
            default:   act_fn = x;
        endcase
    endfunction

    // Bus decode
    logic [AddrWidth-1:0] addr;
    logic                 rd, wr;
    logic                 sel_ctrl, sel_input, sel_output, sel_status;
    logic                 unused_addr_bits;

    assign addr             = addr_i[AddrWidth-1:0];
    assign unused_addr_bits = ^addr_i[DWidth-1:AddrWidth];
    assign rd               = cen_i & ~wen_i;
    assign wr               = cen_i & wen_i;
    assign sel_ctrl         = (addr == AddrWidth'(ADDR_CTRL));
    assign sel_input        = (addr == AddrWidth'(ADDR_INPUT));
    assign sel_output       = (addr == AddrWidth'(ADDR_OUTPUT));
    assign sel_status       = (addr == AddrWidth'(ADDR_STATUS));

    // Control / status state
    act_mode_e mode;
    logic      irq_en;
    logic      flush_q;
    logic      overflow, underflow;

    // FIFO wiring
    logic [DWidth-1:0] in_rdata, out_rdata;
    logic              in_full, in_empty, out_full, out_empty;
    logic [CW-1:0]     in_count, out_count;
    logic              in_push, in_pop, out_pop;
    logic              ovf_set, unf_set;

    // Pipeline
    logic              s1_vld, s2_vld;
    logic [DWidth-1:0] s1_dat, s2_dat;
    act_mode_e         s1_mode;
    logic [CW:0]       occupancy;

    assign in_push = wr & sel_input & ~in_full;
    assign ovf_set = wr & sel_input & in_full;
    assign out_pop = rd & sel_output & ~out_empty;
    assign unf_set = rd & sel_output & out_empty;

    // Reserve output space for everything already in flight so the output FIFO
    // can never overflow and the pipeline never needs a stall.
    assign occupancy = (CW+1)'(out_count) + (CW+1)'(s1_vld) + (CW+1)'(s2_vld);
    assign in_pop    = ~in_empty & ~flush_q & (occupancy < (CW+1)'(FifoDepth));

    sync_fifo #(.DWidth(DWidth), .Depth(FifoDepth)) u_in_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (flush_q),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (wdata_i),
        .rdata (in_rdata),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    sync_fifo #(.DWidth(DWidth), .Depth(FifoDepth)) u_out_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (flush_q),
        .push  (s2_vld),
        .pop   (out_pop),
        .wdata (s2_dat),
        .rdata (out_rdata),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    // Read mux
    logic [DWidth-1:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        if (sel_ctrl) begin
            rd_mux[1:0]         = mode;
            rd_mux[CTRL_IRQ_EN] = irq_en;
        end else if (sel_output) begin
            rd_mux = out_empty ? '0 : out_rdata;
        end else if (sel_status) begin
            rd_mux[STAT_IN_EMPTY]       = in_empty;
            rd_mux[STAT_IN_FULL]        = in_full;
            rd_mux[STAT_OUT_EMPTY]      = out_empty;
            rd_mux[STAT_OUT_FULL]       = out_full;
            rd_mux[STAT_OVERFLOW]       = overflow;
            rd_mux[STAT_UNDERFLOW]      = underflow;
            rd_mux[STAT_BUSY]           = s1_vld | s2_vld;
            rd_mux[STAT_CNT_LSB +: 8]   = 8'(out_count);
        end
    end

    logic w1c;
    assign w1c = wr & sel_status;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode      <= ACT_IDENT;
            irq_en    <= 1'b0;
            flush_q   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s1_dat    <= '0;
            s1_mode   <= ACT_IDENT;
            s2_dat    <= '0;
            rdata_o   <= '0;
            irq_o     <= 1'b0;
        end else begin
            flush_q <= wr & sel_ctrl & wdata_i[CTRL_FLUSH];
            if (wr && sel_ctrl) begin
                mode   <= act_mode_e'(wdata_i[1:0]);
                irq_en <= wdata_i[CTRL_IRQ_EN];
            end

            // Mode travels with each element so later CTRL writes leave it alone
            s1_vld <= in_pop;
            if (in_pop) begin
                s1_dat  <= in_rdata;
                s1_mode <= mode;
            end
            s2_vld <= s1_vld & ~flush_q;
            if (s1_vld) begin
                s2_dat <= act_fn(s1_dat, s1_mode);
            end

            // Sticky bits: a same-cycle set beats the W1C clear
            overflow  <= ovf_set | (overflow  & ~(w1c & wdata_i[STAT_OVERFLOW]));
            underflow <= unf_set | (underflow & ~(w1c & wdata_i[STAT_UNDERFLOW]));

            if (rd) begin
                rdata_o <= rd_mux;
            end
            irq_o <= irq_en & ~out_empty;
        end
    end

    logic unused_in_count;
    assign unused_in_count = ^in_count;

endmodule
